fma_share_sched: RTL and testbench
==================================

// Module: fma_share_sched
// PURPOSE
//  Schedules two requesters onto one shared, pipelined a*b+addend datapath.
//  When both requesters present identical (a,b), it issues them together.
//  The single product then feeds both adders, giving two results for one multiply.
//  Otherwise it arbitrates round-robin, one issue per cycle.
//  Sits in front of the sum-of-products datapath; results return with fixed latency.
// PARAMETERS
//  BW     8   operand width (a, b, addend)
//  CNT_W  16  width of the shared-issue statistics counter
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       async active-high reset
//  share_en    in   1       1: allow fused issue of matching (a,b); 0: never fuse
//  req0_valid  in   1       requester 0 has an operation
//  req0_ready  out  1       requester 0 operation accepted this cycle
//  req0_a      in   BW      multiplicand
//  req0_b      in   BW      multiplier
//  req0_c      in   BW      addend
//  req1_valid  in   1       requester 1 has an operation
//  req1_ready  out  1       requester 1 operation accepted this cycle
//  req1_a      in   BW      multiplicand
//  req1_b      in   BW      multiplier
//  req1_c      in   BW      addend
//  res0_valid  out  1       result for requester 0 valid (1-cycle pulse)
//  res0_data   out  2*BW    req0_a*req0_b+req0_c
//  res1_valid  out  1       result for requester 1 valid (1-cycle pulse)
//  res1_data   out  2*BW    req1_a*req1_b+req1_c
//  shared_cnt  out  CNT_W   number of fused issues since reset; saturating
// BEHAVIOUR
//  Reset (async, rst=1): rr_ptr=0; pipeline valids=0; res*_valid=0; res*_data=0; shared_cnt=0.
//   Reset mid-operation drops all in-flight ops; no result pulses after rst deasserts.
//  Grant logic is combinational; reqN_ready=grantN; handshake = reqN_valid & reqN_ready.
//   Ready may depend on valid; a requester must not make valid depend on ready.
//   Ready is never 1 while the matching valid is 0.
//  Grant rules (evaluated each cycle):
//   neither valid             -> no grant; rr_ptr holds
//   only reqN valid           -> grant N; rr_ptr <= ~N
//   both valid, share_en=1, a0==a1, b0==b1 -> grant both (fused);
//     rr_ptr holds; shared_cnt++ (holds at 2^CNT_W-1)
//   both valid, not fusable   -> grant rr_ptr; rr_ptr <= ~rr_ptr
//  Pipeline: 2 stages, no backpressure; issue accepted every cycle.
//   S1 (edge after handshake): register product p=a*b, addends, per-lane valid.
//     A fused issue computes one product, used by both lanes.
//   S2 (next edge): res0_data=p+c0 and/or res1_data=p+c1; resN_valid=1 for granted lanes.
//   Latency: handshake in cycle T -> resN_valid high in cycle T+2, for exactly 1 cycle.
//   resN_data holds its last value when resN_valid=0.
//  Arithmetic: unsigned; (2^BW-1)^2+(2^BW-1) < 2^(2*BW), so no overflow or truncation.
//  Ordering: per-requester results return in issue order; throughput 1 op/cycle total.
//   A fused issue gives 2 ops/cycle.
//  share_en is sampled in the same cycle as the grant; toggling it affects only new grants.
// TESTING
//  Reset: rst=1 mid-stream with ops in S1/S2 -> all outputs 0, no res pulses after release.
//  Single: req0 a=3,b=5,c=7 alone at T -> req0_ready=1 at T; res0_valid,res0_data=22 at T+2;
//   rr_ptr=1.
//  Fuse: share_en=1, both a=255,b=255, c0=255,c1=0 -> both ready; same cycle +2:
//   res0=65280, res1=65025; shared_cnt=1.
//  Round-robin: both valid every cycle, a0=2,a1=3 (no match) -> grants alternate 0,1,0,1
//   from reset; results alternate at +2.
//  share_en=0 with matching (a,b) -> no fuse; one grant per cycle (rr order);
//   shared_cnt unchanged.
//  Saturation: CNT_W=2, 5 fused issues -> shared_cnt stays at 3.

Source files
------------

// File: rtl/fma_share_sched.sv
// Two-requester scheduler in front of a shared 2-stage a*b+c pipeline.
// Matching (a,b) pairs share one multiply; otherwise round-robin issue.
module fma_share_sched #(
   parameter int BW    = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              share_en,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [BW-1:0]     req0_a,
   input  logic [BW-1:0]     req0_b,
   input  logic [BW-1:0]     req0_c,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [BW-1:0]     req1_a,
   input  logic [BW-1:0]     req1_b,
   input  logic [BW-1:0]     req1_c,
   output logic              res0_valid,
   output logic [2*BW-1:0]   res0_data,
   output logic              res1_valid,
   output logic [2*BW-1:0]   res1_data,
   output logic [CNT_W-1:0]  shared_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic            rr_ptr;
   logic            fuse;
   logic            grant0;
   logic            grant1;
   logic [BW-1:0]   op_a;
   logic [BW-1:0]   op_b;
   logic [2*BW-1:0] prod;

   logic            s1_v0;
   logic            s1_v1;
   logic [2*BW-1:0] s1_p;
   logic [BW-1:0]   s1_c0;
   logic [BW-1:0]   s1_c1;

   always_comb begin
      fuse = req0_valid & req1_valid & share_en
           & (req0_a == req1_a) & (req0_b == req1_b);
      grant0 = req0_valid & (fuse | ~req1_valid | ~rr_ptr);
      grant1 = req1_valid & (fuse | ~req0_valid | rr_ptr);
      // A fused issue carries identical operands, so lane 0's copy serves both
      op_a = grant0 ? req0_a : req1_a;
      op_b = grant0 ? req0_b : req1_b;
      prod = {{BW{1'b0}}, op_a} * {{BW{1'b0}}, op_b};
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (grant0 & ~grant1) begin
         rr_ptr <= 1'b1;
      end else if (grant1 & ~grant0) begin
         rr_ptr <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v0 <= 1'b0;
         s1_v1 <= 1'b0;
         s1_p  <= '0;
         s1_c0 <= '0;
         s1_c1 <= '0;
      end else begin
         s1_v0 <= grant0;
         s1_v1 <= grant1;
         s1_p  <= prod;
         s1_c0 <= req0_c;
         s1_c1 <= req1_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         res0_data  <= '0;
         res1_data  <= '0;
      end else begin
         res0_valid <= s1_v0;
         res1_valid <= s1_v1;
         if (s1_v0) res0_data <= s1_p + {{BW{1'b0}}, s1_c0};
         if (s1_v1) res1_data <= s1_p + {{BW{1'b0}}, s1_c1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shared_cnt <= '0;
      end else if (fuse && shared_cnt != CNT_MAX) begin
         shared_cnt <= shared_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fma_share_sched.sv
// Scoreboard bench for fma_share_sched: stimulus pushes expected results,
// a negedge monitor pops and compares; a CNT_W=2 copy covers saturation.
module tb_fma_share_sched;

   localparam int BW = 8;

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        share_en = 1'b0;
   logic        req0_valid = 1'b0;
   logic        req1_valid = 1'b0;
   logic [7:0]  req0_a = '0, req0_b = '0, req0_c = '0;
   logic [7:0]  req1_a = '0, req1_b = '0, req1_c = '0;
   logic        req0_ready, req1_ready;
   logic        res0_valid, res1_valid;
   logic [15:0] res0_data, res1_data;
   logic [15:0] shared_cnt;
   logic        sat_ready0, sat_ready1, sat_rv0, sat_rv1;
   logic [15:0] sat_rd0, sat_rd1;
   logic [1:0]  sat_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [15:0] last0 = '0;
   logic [15:0] last1 = '0;
   int m_rr = 0;
   int m_cnt = 0;

   fma_share_sched #(.BW(BW), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .share_en(share_en),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
      .res0_valid(res0_valid), .res0_data(res0_data),
      .res1_valid(res1_valid), .res1_data(res1_data),
      .shared_cnt(shared_cnt)
   );

   fma_share_sched #(.BW(BW), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .share_en(share_en),
      .req0_valid(req0_valid), .req0_ready(sat_ready0),
      .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
      .req1_valid(req1_valid), .req1_ready(sat_ready1),
      .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
      .res0_valid(sat_rv0), .res0_data(sat_rd0),
      .res1_valid(sat_rv1), .res1_data(sat_rd1),
      .shared_cnt(sat_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each result pulse against the scoreboard head
   always @(negedge clk) begin
      if (!rst) begin
         if (res0_valid) begin
            if (q0.size() == 0) begin
               chk("res0_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = q0.pop_front();
               chk("res0_data", int'(res0_data), int'(e.data));
               chk("res0_latency", cyc, e.due);
            end
            last0 = res0_data;
         end else begin
            chk("res0_hold", int'(res0_data), int'(last0));
            if (q0.size() != 0 && q0[0].due <= cyc) begin
               chk("res0_missing", 0, 1);
               void'(q0.pop_front());
            end
         end
         if (res1_valid) begin
            if (q1.size() == 0) begin
               chk("res1_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = q1.pop_front();
               chk("res1_data", int'(res1_data), int'(e.data));
               chk("res1_latency", cyc, e.due);
            end
            last1 = res1_data;
         end else begin
            chk("res1_hold", int'(res1_data), int'(last1));
            if (q1.size() != 0 && q1[0].due <= cyc) begin
               chk("res1_missing", 0, 1);
               void'(q1.pop_front());
            end
         end
      end
   end

   // One cycle of stimulus; the reference model decides grants from the rules
   task automatic issue(input bit v0, input int a0, input int b0, input int c0,
                        input bit v1, input int a1, input int b1, input int c1,
                        input bit se);
      bit g0, g1, fz;
      exp_t e;
      @(posedge clk);
      #1;
      chk("shared_cnt", int'(shared_cnt), m_cnt);
      chk("sat_cnt", int'(sat_cnt), (m_cnt > 3) ? 3 : m_cnt);
      share_en = se;
      req0_valid = v0; req0_a = a0[7:0]; req0_b = b0[7:0]; req0_c = c0[7:0];
      req1_valid = v1; req1_a = a1[7:0]; req1_b = b1[7:0]; req1_c = c1[7:0];
      #1;
      fz = v0 && v1 && se && (a0 == a1) && (b0 == b1);
      g0 = 0; g1 = 0;
      if (fz) begin
         g0 = 1; g1 = 1;
         m_cnt++;
      end else if (v0 && v1) begin
         g0 = (m_rr == 0);
         g1 = (m_rr == 1);
         m_rr = 1 - m_rr;
      end else if (v0) begin
         g0 = 1; m_rr = 1;
      end else if (v1) begin
         g1 = 1; m_rr = 0;
      end
      chk("req0_ready", int'(req0_ready), int'(g0));
      chk("req1_ready", int'(req1_ready), int'(g1));
      if (g0) begin
         e.due = cyc + 2;
         e.data = 16'(a0 * b0 + c0);
         q0.push_back(e);
      end
      if (g1) begin
         e.due = cyc + 2;
         e.data = 16'(a1 * b1 + c1);
         q1.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      req0_valid = 0;
      req1_valid = 0;
      #1;
      chk("rst_res0_valid", int'(res0_valid), 0);
      chk("rst_res1_valid", int'(res1_valid), 0);
      chk("rst_res0_data", int'(res0_data), 0);
      chk("rst_res1_data", int'(res1_data), 0);
      chk("rst_cnt", int'(shared_cnt), 0);
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
      m_rr = 0;
      m_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int a, b;
      do_reset();
      idle(2);

      // Lone request: 3*5+7
      issue(1, 3, 5, 7, 0, 0, 0, 0, 1);
      idle(3);
      chk("single_last0", int'(last0), 22);

      // Fused max operands
      issue(1, 255, 255, 255, 1, 255, 255, 0, 1);
      idle(3);
      chk("fuse_res0", int'(last0), 65280);
      chk("fuse_res1", int'(last1), 65025);

      // Round-robin with mismatched a after reset
      do_reset();
      for (int i = 0; i < 6; i++) issue(1, 2, 7, i, 1, 3, 7, i, 1);
      idle(3);

      // Matching operands with sharing disabled
      for (int i = 0; i < 4; i++) issue(1, 9, 9, i, 1, 9, 9, 10 + i, 0);
      idle(3);

      // Saturation of the narrow counter
      for (int i = 0; i < 6; i++) issue(1, 4, 6, i, 1, 4, 6, 2 * i, 1);
      idle(3);

      // Randomized traffic with a bias toward matching operands
      for (int i = 0; i < 400; i++) begin
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         if ($urandom_range(0, 2) == 0)
            issue($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0, a, b, $urandom_range(0, 255),
                  $urandom_range(0, 1) == 1);
         else
            issue($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 1) == 1);
      end

      // Reset with ops in flight: nothing may emerge afterwards
      issue(1, 11, 12, 13, 1, 11, 12, 14, 1);
      issue(1, 21, 22, 23, 1, 1, 2, 3, 1);
      do_reset();
      idle(5);
      issue(1, 100, 200, 50, 1, 7, 8, 9, 1);
      idle(4);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
